dma_priority_arbiter: RTL

DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

---
 rtl/dma_priority_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter
//   Four-channel DMA request arbiter with a DREQ synchronizer, mask and
//   software-request registers, fixed or rotating priority, and an
//   IDLE/PENDING/ACTIVE grant sequence driven by hold acknowledge.
//
// Ports
//   Clock, Reset, MasterClear   : clock; synchronous active-high clears
//   DREQ[3:0]                   : raw asynchronous channel requests
//   CommandReg[7:0]             : [2] disable, [4] rotate, [6] DREQ low, [7] DACK high
//   AutoInit[3:0]               : per-channel autoinitialize enable
//   MaskLoad/MaskData           : write all mask bits
//   ClearMask                   : clear all mask bits
//   SingleMaskLoad/SingleMaskData : [1:0] channel, [2] set/clear one mask bit
//   ReqRegLoad/ReqRegData       : [1:0] channel, [2] set/clear software request
//   Hlda                        : hold acknowledge
//   ServiceDone, TCReached[3:0] : end-of-service pulse and terminal counts
//   ReqID, ValidReqID           : winning channel and qualifier
//   DACK[3:0]                   : channel acknowledges (polarity CommandReg[7])
//   MaskReg, ReqStatus          : mask bits and effective requests
module dma_priority_arbiter #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       MasterClear,
  input  logic [3:0] DREQ,
  input  logic [7:0] CommandReg,
  input  logic [3:0] AutoInit,
  input  logic       MaskLoad,
  input  logic [3:0] MaskData,
  input  logic       ClearMask,
  input  logic       SingleMaskLoad,
  input  logic [2:0] SingleMaskData,
  input  logic       ReqRegLoad,
  input  logic [2:0] ReqRegData,
  input  logic       Hlda,
  input  logic       ServiceDone,
  input  logic [3:0] TCReached,
  output logic [1:0] ReqID,
  output logic       ValidReqID,
  output logic [3:0] DACK,
  output logic [3:0] MaskReg,
  output logic [3:0] ReqStatus
);

  typedef enum logic [1:0] {IDLE, PENDING, ACTIVE} state_e;

  state_e     state_q, state_d;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_d [SYNC_STAGES];
  logic [1:0] req_id_q, req_id_d;
  logic       valid_q, valid_d;
  logic [1:0] last_q, last_d;
  logic [3:0] sw_q, sw_d;
  logic [3:0] mask_q, mask_d;

  logic       clr;
  logic [3:0] sreq;
  logic [3:0] eff_req;
  logic [1:0] base;
  logic [1:0] cand;
  logic [1:0] win;
  logic       found;
  logic       tc_mask;
  logic [3:0] dack_act;
  logic       unused_cmd;

  assign clr        = Reset | MasterClear;
  assign unused_cmd = ^{CommandReg[5], CommandReg[3], CommandReg[1:0]};

  always_comb begin
    sync_d[0] = DREQ;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sreq    = sync_q[SYNC_STAGES-1] ^ {4{CommandReg[6]}};
  assign eff_req = (sreq & ~mask_q) | sw_q;

  // Scan four candidates starting at base; 2-bit wrap gives the rotation.
  always_comb begin
    base  = CommandReg[4] ? last_q + 2'd1 : 2'd0;
    win   = base;
    found = 1'b0;
    cand  = base;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = base + 2'(k);
      if (!found && eff_req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    req_id_d = req_id_q;
    valid_d  = valid_q;
    last_d   = last_q;
    sw_d     = sw_q;
    tc_mask  = 1'b0;

    if (CommandReg[2]) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|eff_req) begin
            req_id_d = win;
            valid_d  = 1'b1;
            state_d  = PENDING;
          end
        end
        PENDING: begin
          if (!eff_req[req_id_q]) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else if (Hlda) begin
            state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          if (ServiceDone) begin
            state_d          = IDLE;
            valid_d          = 1'b0;
            last_d           = req_id_q;
            sw_d[req_id_q]   = 1'b0;
            tc_mask          = TCReached[req_id_q] & ~AutoInit[req_id_q];
          end else if (!Hlda) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end

    if (ReqRegLoad) begin
      sw_d[ReqRegData[1:0]] = ReqRegData[2];
    end

    // Single-bit load is applied after the TC auto-mask so it wins on the
    // same channel, while both land when the channels differ.
    if (ClearMask) begin
      mask_d = '0;
    end else if (MaskLoad) begin
      mask_d = MaskData;
    end else begin
      mask_d = mask_q;
      if (tc_mask) begin
        mask_d[req_id_q] = 1'b1;
      end
      if (SingleMaskLoad) begin
        mask_d[SingleMaskData[1:0]] = SingleMaskData[2];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (clr) begin
      state_q  <= IDLE;
      req_id_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 2'd3;
      sw_q     <= '0;
      mask_q   <= '1;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      req_id_q <= req_id_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      sw_q     <= sw_d;
      mask_q   <= mask_d;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  always_comb begin
    dack_act = '0;
    if (state_q == ACTIVE) begin
      dack_act[req_id_q] = 1'b1;
    end
  end

  assign DACK       = CommandReg[7] ? dack_act : ~dack_act;
  assign ReqID      = req_id_q;
  assign ValidReqID = valid_q;
  assign MaskReg    = mask_q;
  assign ReqStatus  = eff_req;

endmodule
